// File: rtl/adder_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : adder_pipe_if                                                |
// | Description : Operand/result handshake bundle for adder_pipe.              |
// |               Upstream side: in_valid/in_ready with in1, in2, op, cin.     |
// |               Downstream side: out_valid/out_ready with o, cout, ovf, zero.|
// |               master = traffic source/sink, slave = the adder itself.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface adder_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [1:0]       op;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] o;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, in1, in2, op, cin, out_ready,
    input  in_ready, out_valid, o, cout, ovf, zero
  );

  modport slave (
    input  in_valid, in1, in2, op, cin, out_ready,
    output in_ready, out_valid, o, cout, ovf, zero
  );
endinterface
`default_nettype wire

// File: rtl/adder_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : adder_pipe                                                   |
// | Description : Pipelined WIDTH-bit add/subtract split into STAGES segments  |
// |               of SEG = WIDTH/STAGES bits, carry registered between them.   |
// |               Valid/ready flow control, op select, carry-in and            |
// |               carry/overflow/zero flags registered with the result.        |
// | Ports       : clk    - rising-edge clock                                   |
// |               rst_n  - synchronous active-low reset                        |
// |               bus    - adder_pipe_if.slave (operands in, result out)       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  adder_pipe_if.slave  bus
);
  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Per-stage view: what stage k sees (a, b', carry, partial sum, valid) and
  // what it produces (partial sum with segment k filled in, carry out).
  logic [WIDTH-1:0] w_a_in  [STAGES];
  logic [WIDTH-1:0] w_b_in  [STAGES];
  logic [WIDTH-1:0] w_s_in  [STAGES];
  logic [WIDTH-1:0] w_s_out [STAGES];
  logic             w_c_in  [STAGES];
  logic             w_c_out [STAGES];
  logic             w_v_in  [STAGES];
  logic [SEG-1:0]   w_seg   [STAGES];

  logic             w_adv;
  logic [WIDTH-1:0] w_b_prep;
  logic             w_c0;
  logic             w_ovf;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_o;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  // The whole pipe moves as one; it only stalls when a result is parked.
  assign w_adv        = !r_out_valid || bus.out_ready;
  assign bus.in_ready = w_adv;

  // Subtraction is A + ~B + 1; borrow-in variant uses cin in place of the 1.
  assign w_b_prep = bus.op[0] ? ~bus.in2 : bus.in2;

  always_comb begin
    w_c0 = 1'b0;
    case (bus.op)
      2'b00:   w_c0 = 1'b0;
      2'b01:   w_c0 = 1'b1;
      default: w_c0 = bus.cin;
    endcase
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign w_a_in[k] = bus.in1;
      assign w_b_in[k] = w_b_prep;
      assign w_c_in[k] = w_c0;
      assign w_s_in[k] = '0;
      assign w_v_in[k] = bus.in_valid;
    end else begin : g_reg
      logic [WIDTH-1:0] r_a;
      logic [WIDTH-1:0] r_b;
      logic [WIDTH-1:0] r_s;
      logic             r_c;
      logic             r_v;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
          r_s <= '0;
          r_c <= 1'b0;
          r_v <= 1'b0;
        end else if (w_adv) begin
          r_a <= w_a_in[k-1];
          r_b <= w_b_in[k-1];
          r_s <= w_s_out[k-1];
          r_c <= w_c_out[k-1];
          r_v <= w_v_in[k-1];
        end
      end

      assign w_a_in[k] = r_a;
      assign w_b_in[k] = r_b;
      assign w_c_in[k] = r_c;
      assign w_s_in[k] = r_s;
      assign w_v_in[k] = r_v;
    end

    assign {w_c_out[k], w_seg[k]} = {1'b0, w_a_in[k][k*SEG +: SEG]}
                                  + {1'b0, w_b_in[k][k*SEG +: SEG]}
                                  + {{SEG{1'b0}}, w_c_in[k]};

    // Segments not yet computed are always zero in the partial sum, so OR
    // drops segment k into place without disturbing the finished ones.
    assign w_s_out[k] = w_s_in[k] | (WIDTH'(w_seg[k]) << (k * SEG));
  end

  assign w_ovf = (w_a_in[LAST][WIDTH-1] == w_b_in[LAST][WIDTH-1])
              && (w_s_out[LAST][WIDTH-1] != w_a_in[LAST][WIDTH-1]);

  // Result and flags load only from a real beat, so o keeps its last value
  // while bubbles pass through.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_o         <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= w_v_in[LAST];
      if (w_v_in[LAST]) begin
        r_o    <= w_s_out[LAST];
        r_cout <= w_c_out[LAST];
        r_ovf  <= w_ovf;
        r_zero <= (w_s_out[LAST] == '0);
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.o         = r_o;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
  assign bus.zero      = r_zero;

endmodule
`default_nettype wire
